// File: rtl/pio_input_conditioner_if.sv
// pio_input_conditioner_if: board-pin side and PIO side signals of the input conditioner
// Signals:
//   key_raw, sw_raw     raw asynchronous pushbutton / slide-switch pins
//   edge_clear          per-button level-sensitive clear of the sticky capture
//   button/dipsw export debounced levels for the soc_system PIOs (1 = pressed)
//   btn_press_pulse, btn_release_pulse, sw_change_pulse  one-cycle event pulses
//   btn_edge_capture    sticky per-button press flags
// master drives the raw pins and clears; slave is the conditioner itself.
interface pio_input_conditioner_if #(
    parameter int N_BTN = 4,
    parameter int N_SW  = 10
);
    logic [N_BTN-1:0] key_raw;
    logic [N_SW-1:0]  sw_raw;
    logic [N_BTN-1:0] edge_clear;
    logic [N_BTN-1:0] button_pio_external_connection_export;
    logic [N_SW-1:0]  dipsw_pio_external_connection_export;
    logic [N_BTN-1:0] btn_press_pulse;
    logic [N_BTN-1:0] btn_release_pulse;
    logic [N_SW-1:0]  sw_change_pulse;
    logic [N_BTN-1:0] btn_edge_capture;

    modport master (
        output key_raw, sw_raw, edge_clear,
        input  button_pio_external_connection_export, dipsw_pio_external_connection_export,
        input  btn_press_pulse, btn_release_pulse, sw_change_pulse, btn_edge_capture
    );

    modport slave (
        input  key_raw, sw_raw, edge_clear,
        output button_pio_external_connection_export, dipsw_pio_external_connection_export,
        output btn_press_pulse, btn_release_pulse, sw_change_pulse, btn_edge_capture
    );
endinterface

// File: rtl/pio_input_conditioner.sv
// pio_input_conditioner: synchronize and debounce board buttons/switches for the soc_system PIOs
// Ports:
//   clk_clk      fabric clock
//   reset_reset  asynchronous active-high reset
//   pio          slave side of pio_input_conditioner_if (raw pins in, clean levels/pulses/capture out)
module pio_input_conditioner #(
    parameter int N_BTN           = 4,
    parameter int N_SW            = 10,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20,
    parameter int BTN_ACTIVE_LOW  = 1
) (
    input logic                  clk_clk,
    input logic                  reset_reset,
    pio_input_conditioner_if.slave pio
);
    localparam int N = N_BTN + N_SW;
    // Inactive raw level per bit; also the mask that normalizes buttons to 1 = pressed.
    localparam logic [N-1:0] INACT = {{N_SW{1'b0}}, {N_BTN{BTN_ACTIVE_LOW != 0}}};

    typedef enum logic {STABLE, COUNTING} state_t;

    logic [N-1:0]     sync1_q, sync2_q, s;
    logic [N-1:0]     stable_q, stable_d, change;
    state_t           state_q [N];
    state_t           state_d [N];
    logic [CNT_W-1:0] cnt_q [N];
    logic [CNT_W-1:0] cnt_d [N];
    logic [N_BTN-1:0] press_q, release_q, cap_q, cap_d;
    logic [N_SW-1:0]  swchg_q;

    assign s = sync2_q ^ INACT;

    always_comb begin
        stable_d = stable_q;
        for (int i = 0; i < N; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            if (state_q[i] == STABLE) begin
                if (s[i] != stable_q[i]) begin
                    state_d[i] = COUNTING;
                    cnt_d[i]   = CNT_W'(1);
                end
            end else if (s[i] == stable_q[i]) begin
                state_d[i] = STABLE;
                cnt_d[i]   = '0;
            end else if (cnt_q[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                stable_d[i] = s[i];
                state_d[i]  = STABLE;
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Pulses are registered alongside the stable value, so they coincide with the level change.
    assign change = stable_d ^ stable_q;
    // A press pulse already registered sets the flag even when clear is high.
    assign cap_d  = (cap_q & ~pio.edge_clear) | press_q;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sync1_q   <= INACT;
            sync2_q   <= INACT;
            stable_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
            swchg_q   <= '0;
            cap_q     <= '0;
            for (int i = 0; i < N; i++) begin
                state_q[i] <= STABLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            sync1_q   <= {pio.sw_raw, pio.key_raw};
            sync2_q   <= sync1_q;
            stable_q  <= stable_d;
            press_q   <= change[N_BTN-1:0] & stable_d[N_BTN-1:0];
            release_q <= change[N_BTN-1:0] & ~stable_d[N_BTN-1:0];
            swchg_q   <= change[N-1:N_BTN];
            cap_q     <= cap_d;
            for (int i = 0; i < N; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign pio.button_pio_external_connection_export = stable_q[N_BTN-1:0];
    assign pio.dipsw_pio_external_connection_export  = stable_q[N-1:N_BTN];
    assign pio.btn_press_pulse                       = press_q;
    assign pio.btn_release_pulse                     = release_q;
    assign pio.sw_change_pulse                       = swchg_q;
    assign pio.btn_edge_capture                      = cap_q;
endmodule

// File: tb/tb_pio_input_conditioner.sv
// tb_pio_input_conditioner: window-based reference model plus directed scenarios for the input conditioner
module tb_pio_input_conditioner;
    localparam int NB = 4;
    localparam int NS = 10;
    localparam int N  = NB + NS;
    localparam int D  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pio_input_conditioner_if #(.N_BTN(NB), .N_SW(NS)) bus ();

    pio_input_conditioner #(
        .N_BTN(NB), .N_SW(NS), .DEBOUNCE_CYCLES(D), .CNT_W(4), .BTN_ACTIVE_LOW(1)
    ) dut (
        .clk_clk(clk),
        .reset_reset(rst),
        .pio(bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: hist[k] is the normalized raw sample taken k+1 edges ago. A bit's level
    // flips when each of the D samples the debouncer has seen (hist[1..D]) disagrees with it.
    logic [N-1:0]  hist [0:D];
    logic [N-1:0]  mq, nq, full;
    logic [NB-1:0] mpress, mrel, mcap;
    logic [NS-1:0] mswc;

    always_comb begin
        full = '1;
        for (int i = 0; i < N; i++)
            for (int k = 1; k <= D; k++)
                if (hist[k][i] == mq[i]) full[i] = 1'b0;
        nq = mq ^ full;
    end

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k <= D; k++) hist[k] <= '0;
            mq <= '0; mpress <= '0; mrel <= '0; mcap <= '0; mswc <= '0;
        end else begin
            mcap   <= (mcap & ~bus.edge_clear) | mpress;
            mpress <= nq[NB-1:0] & ~mq[NB-1:0];
            mrel   <= ~nq[NB-1:0] & mq[NB-1:0];
            mswc   <= nq[N-1:NB] ^ mq[N-1:NB];
            mq     <= nq;
            for (int k = 1; k <= D; k++) hist[k] <= hist[k-1];
            hist[0] <= {bus.sw_raw, ~bus.key_raw};
        end
    end

    always @(negedge clk) begin
        chk("btn_level", 32'(bus.button_pio_external_connection_export), 32'(mq[NB-1:0]));
        chk("sw_level", 32'(bus.dipsw_pio_external_connection_export), 32'(mq[N-1:NB]));
        chk("press_pulse", 32'(bus.btn_press_pulse), 32'(mpress));
        chk("release_pulse", 32'(bus.btn_release_pulse), 32'(mrel));
        chk("sw_change", 32'(bus.sw_change_pulse), 32'(mswc));
        chk("capture", 32'(bus.btn_edge_capture), 32'(mcap));
    end

    int press_cnt [NB];
    int rel_cnt [NB];
    int swc_cnt [NS];
    always @(negedge clk) begin
        for (int i = 0; i < NB; i++) begin
            press_cnt[i] <= press_cnt[i] + int'(bus.btn_press_pulse[i]);
            rel_cnt[i]   <= rel_cnt[i] + int'(bus.btn_release_pulse[i]);
        end
        for (int i = 0; i < NS; i++) swc_cnt[i] <= swc_cnt[i] + int'(bus.sw_change_pulse[i]);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_btn(input int b, input logic lvl, output int n);
        n = 0;
        while (bus.button_pio_external_connection_export[b] !== lvl && n < 40) begin
            tick(1);
            n++;
        end
    endtask

    initial begin
        int n, p, r;
        bus.key_raw = '1;
        bus.sw_raw = '0;
        bus.edge_clear = '0;
        tick(3);
        chk("in_reset_btn", 32'(bus.button_pio_external_connection_export), 0);
        chk("in_reset_cap", 32'(bus.btn_edge_capture), 0);
        rst = 1'b0;
        tick(2);
        chk("after_reset_sw", 32'(bus.dipsw_pio_external_connection_export), 0);

        p = press_cnt[0];
        bus.key_raw[0] = 1'b0;
        wait_btn(0, 1'b1, n);
        chk("press_latency", n, 10);
        tick(2);
        chk("press_pulse_count", press_cnt[0] - p, 1);
        chk("capture0_set", 32'(bus.btn_edge_capture[0]), 1);

        p = press_cnt[1];
        r = rel_cnt[1];
        bus.key_raw[1] = 1'b0;
        tick(5);
        bus.key_raw[1] = 1'b1;
        tick(20);
        chk("glitch_level", 32'(bus.button_pio_external_connection_export[1]), 0);
        chk("glitch_press", press_cnt[1] - p, 0);
        chk("glitch_release", rel_cnt[1] - r, 0);
        chk("glitch_capture", 32'(bus.btn_edge_capture[1]), 0);

        p = swc_cnt[9];
        for (int t = 0; t < 11; t++) begin
            bus.sw_raw[9] = ~bus.sw_raw[9];
            if (t < 10) tick(3);
        end
        n = 0;
        while (bus.dipsw_pio_external_connection_export[9] !== 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
        chk("sw_latency", n, 10);
        tick(2);
        chk("sw_change_count", swc_cnt[9] - p, 1);

        bus.key_raw[2] = 1'b0;
        wait_btn(2, 1'b1, n);
        tick(2);
        chk("capture2_set", 32'(bus.btn_edge_capture[2]), 1);
        bus.key_raw[2] = 1'b1;
        wait_btn(2, 1'b0, n);
        chk("release2_latency", n, 10);
        bus.key_raw[2] = 1'b0;
        n = 0;
        while (bus.btn_press_pulse[2] !== 1'b1 && n < 40) begin
            tick(1);
            n++;
        end
        chk("repress2_latency", n, 10);
        bus.edge_clear[2] = 1'b1;
        tick(1);
        chk("set_wins_over_clear", 32'(bus.btn_edge_capture[2]), 1);
        tick(1);
        chk("clear_takes_effect", 32'(bus.btn_edge_capture[2]), 0);
        tick(1);
        chk("clear_idle", 32'(bus.btn_edge_capture[2]), 0);
        bus.edge_clear[2] = 1'b0;
        tick(2);

        p = press_cnt[3];
        bus.key_raw[3] = 1'b0;
        tick(7);
        rst = 1'b1;
        tick(1);
        chk("rst_btn", 32'(bus.button_pio_external_connection_export), 0);
        chk("rst_sw", 32'(bus.dipsw_pio_external_connection_export), 0);
        chk("rst_cap", 32'(bus.btn_edge_capture), 0);
        chk("rst_press", 32'(bus.btn_press_pulse), 0);
        tick(2);
        rst = 1'b0;
        wait_btn(3, 1'b1, n);
        chk("post_reset_latency", n, 10);
        tick(2);
        chk("post_reset_press_count", press_cnt[3] - p, 1);

        bus.key_raw[1] = 1'b0;
        wait_btn(1, 1'b1, n);
        tick(2);
        chk("all_captured", 32'(bus.btn_edge_capture), 32'hF);
        bus.key_raw = '1;
        n = 0;
        while (bus.btn_release_pulse === '0 && n < 40) begin
            tick(1);
            n++;
        end
        chk("all_release_latency", n, 10);
        chk("all_release_same_cycle", 32'(bus.btn_release_pulse), 32'hF);
        chk("release_no_press", 32'(bus.btn_press_pulse), 0);
        tick(1);
        chk("release_single_cycle", 32'(bus.btn_release_pulse), 0);
        chk("capture_unchanged", 32'(bus.btn_edge_capture), 32'hF);
        tick(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pio_input_conditioner.md
Name: pio_input_conditioner

Overview:
- Conditions raw board pushbuttons and slide switches before they reach the SoC system's button and DIP-switch PIO inputs.
- Each bit passes through a 2-FF synchronizer and then a per-bit counter debouncer.
- Delivers clean levels to the PIO exports, plus press/release pulses and a sticky per-button edge-capture register for fabric-side logic.
- Sits between the top-level board pins and the soc_system instance, in the fabric clock domain.

Parameters:
- N_BTN, 4: number of pushbuttons.
- N_SW, 10: number of slide switches.
- DEBOUNCE_CYCLES, 1000000: cycles an input must hold a new value before it is accepted (20 ms at 50 MHz); legal range 2..2^CNT_W-1.
- CNT_W, 20: debounce counter width.
- BTN_ACTIVE_LOW, 1: 1 = raw buttons read 0 when pressed; outputs are always active-high "pressed".

Ports:
- clk_clk  in  1  fabric clock, same as soc_system clk_clk.
- reset_reset  in  1  asynchronous, active-high reset.
- key_raw  in  N_BTN  raw pushbutton pins, asynchronous.
- sw_raw  in  N_SW  raw slide-switch pins, asynchronous.
- button_pio_external_connection_export  out  N_BTN  debounced button levels, 1 = pressed.
- dipsw_pio_external_connection_export  out  N_SW  debounced switch levels.
- btn_press_pulse  out  N_BTN  one-cycle pulse per accepted press.
- btn_release_pulse  out  N_BTN  one-cycle pulse per accepted release.
- sw_change_pulse  out  N_SW  one-cycle pulse per accepted switch change.
- btn_edge_capture  out  N_BTN  sticky press flags.
- edge_clear  in  N_BTN  per-bit clear of btn_edge_capture, level-sensitive.

Behaviour:
- Reset is asynchronous, active-high, and fixed by the interface. While reset_reset=1:
  - all outputs are 0;
  - synchronizer flops hold the inactive level (1 for buttons if BTN_ACTIVE_LOW, else 0; 0 for switches);
  - stable states are 0, counters are 0, every FSM is in STABLE.
- Reset deassertion is assumed synchronous to clk_clk (reset synchronizer upstream).
- Normalisation: button bits are inverted after the synchronizer when BTN_ACTIVE_LOW=1, so the debouncer always sees 1 = pressed.
- Per-bit FSM (identical for buttons and switches). s = synchronized value, q = stable value:
  - STABLE: counter = 0. If s != q, go to COUNTING with counter = 1.
  - COUNTING, s == q (bounce back): go to STABLE, counter = 0, no pulse.
  - COUNTING, s != q and counter == DEBOUNCE_CYCLES-1: q <= s, go to STABLE, counter = 0, fire the pulse in the same registered cycle that q changes.
  - COUNTING otherwise: counter increments.
- Latency: a clean raw step reaches the export exactly DEBOUNCE_CYCLES+2 cycles after the first clock that samples the new raw value (2 synchronizer + DEBOUNCE_CYCLES).
- Rejection: any glitch shorter than DEBOUNCE_CYCLES synchronized cycles produces no output change and no pulse.
- Pulses are registered. Per button, btn_press_pulse is asserted on the cycle q goes 0->1 and btn_release_pulse on 1->0, never both at once. sw_change_pulse fires on either direction.
- Edge capture, next state = (cap & ~edge_clear) | btn_press_pulse. Set wins over a simultaneous clear, so no press is ever lost. Clearing a bit that is already 0 has no effect.
- Bits are fully independent; simultaneous events on different bits are all reported in the same cycle.
- Counters never wrap: the maximum count reached is DEBOUNCE_CYCLES-1 < 2^CNT_W.
- Reset mid-debounce discards the pending transition; after release the bit is re-evaluated from the inactive state. A button held pressed through reset is accepted DEBOUNCE_CYCLES+2 cycles after reset release, with a press pulse.
- All outputs are registered; there is no combinational path from any input to any output.

Test Plan (DEBOUNCE_CYCLES=8, BTN_ACTIVE_LOW=1):
- key_raw[0] goes 1->0 and holds -> button export[0] rises 10 cycles later; btn_press_pulse[0] high exactly 1 cycle; btn_edge_capture[0]=1.
- key_raw[1] pulses low for 5 cycles, then returns high -> no export change, no pulses, capture stays 0; the counter returns to 0.
- sw_raw[9] toggles every 3 cycles for 30 cycles, then settles at 1 -> dipsw export[9]=1 exactly 10 cycles after the final toggle; exactly one sw_change_pulse[9].
- Capture[2] set and edge_clear[2] held high; a new press pulse lands on the same cycle -> capture[2] stays 1. Next cycle, with clear still high and no pulse -> 0.
- Key 3 pressed, reset_reset asserted at counter=5 for 3 cycles, then released with key still pressed -> outputs 0 during reset; export[3] rises 10 cycles after release with one press pulse.
- All 4 keys released simultaneously after a press -> all 4 btn_release_pulse bits high in the same single cycle; capture unchanged.
